adc_scan_sequencer: RTL and testbench

ADC_SCAN_SEQUENCER -- requirements
Module: adc_scan_sequencer

---
 rtl/adc_pkg.sv | 49 ++++
 rtl/sample_fifo.sv | 53 +++++
 rtl/adc_scan_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_adc_scan_sequencer.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// adc_pkg: shared definitions for the ADC scan sequencer.
//   - converter data / channel widths
//   - scan FSM state encoding
//   - FIFO entry layout {ch, data}
//   - channel-selection helpers used when a new conversion is set up
package adc_pkg;

  localparam int ADC_DATA_BITS = 12;
  localparam int ADC_CH_BITS   = 3;
  localparam int ADC_NUM_CH    = 1 << ADC_CH_BITS;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_PULSE   = 3'd2,
    S_CLEAR   = 3'd3,
    S_WAIT    = 3'd4,
    S_CAPTURE = 3'd5,
    S_HOLD    = 3'd6
  } state_t;

  typedef struct packed {
    logic [ADC_CH_BITS-1:0]   ch;
    logic [ADC_DATA_BITS-1:0] data;
  } fifo_entry_t;

  // Lowest set bit of the mask; 0 when the mask is empty (never used then).
  function automatic logic [ADC_CH_BITS-1:0] lowest_ch(input logic [ADC_NUM_CH-1:0] mask);
    lowest_ch = '0;
    for (int i = ADC_NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) lowest_ch = i[ADC_CH_BITS-1:0];
    end
  endfunction

  // Lowest set bit strictly above cur, wrapping to the lowest set bit overall.
  function automatic logic [ADC_CH_BITS-1:0] next_ch(input logic [ADC_NUM_CH-1:0] mask,
                                                     input logic [ADC_CH_BITS-1:0] cur);
    logic found;
    next_ch = lowest_ch(mask);
    found   = 1'b0;
    for (int i = 0; i < ADC_NUM_CH; i++) begin
      if (!found && mask[i] && (i > int'(cur))) begin
        next_ch = i[ADC_CH_BITS-1:0];
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: show-ahead synchronous FIFO holding captured samples.
//   i_push / i_push_data : write request and entry
//   i_pop                : consume the head (ignored when empty)
//   o_head_data          : current head, forced to 0 while empty
//   o_full / o_empty     : occupancy flags
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module sample_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 15
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_pop_ok;
  logic             w_push_ok;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~o_full | w_pop_ok);

  assign o_head_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: it is only visible through the pointers.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
  end

endmodule

// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: scans the channels selected by ch_mask, one conversion
// per sample period, and queues {channel, data} samples in a show-ahead FIFO.
//   clk, reset_n         : clock, asynchronous active-low reset
//   enable, ch_mask      : scan control (mask sampled in IDLE and HOLD)
//   adc_start, adc_ch    : converter start pulse and channel select
//   adc_done, adc_data   : converter completion level and result
//   out_data/out_ch/out_valid/out_ready : sample stream out of the FIFO
//   overrun, timeout_err : sticky error flags, cleared on enable rising
//   busy, dbg_state      : FSM activity and raw state for observation
// Output handshake: a sample transfers on every posedge where
// out_valid=1 and out_ready=1; the head is held unchanged otherwise.
module adc_scan_sequencer
  import adc_pkg::*;
#(
  parameter int SAMPLE_DIV   = 100,
  parameter int DONE_TIMEOUT = 255,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic [ADC_NUM_CH-1:0]    ch_mask,
  output logic                     adc_start,
  output logic [ADC_CH_BITS-1:0]   adc_ch,
  input  logic                     adc_done,
  input  logic [ADC_DATA_BITS-1:0] adc_data,
  output logic [ADC_DATA_BITS-1:0] out_data,
  output logic [ADC_CH_BITS-1:0]   out_ch,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     overrun,
  output logic                     timeout_err,
  output logic                     busy,
  output logic [2:0]               dbg_state
);

  localparam int PW = $clog2(SAMPLE_DIV);
  localparam logic [PW-1:0] PERIOD_MAX = PW'(SAMPLE_DIV - 1);
  // HOLD must hand over two cycles early: SETUP and then PULSE land on the
  // cycle where the period counter reaches SAMPLE_DIV-1.
  localparam logic [PW-1:0] HOLD_EXIT  = PW'((SAMPLE_DIV > 3) ? SAMPLE_DIV - 3 : 0);
  localparam logic [7:0]    WAIT_LIMIT = 8'(DONE_TIMEOUT - 1);

  state_t                   r_state;
  state_t                   w_next;
  logic [PW-1:0]            r_period;
  logic [7:0]               r_wait;
  logic [ADC_CH_BITS-1:0]   r_ch;
  logic [ADC_DATA_BITS-1:0] r_data;
  logic                     r_timed_out;
  logic                     r_en_d;
  logic                     r_overrun;
  logic                     r_timeout_err;

  logic        w_scan_ok;
  logic        w_wait_expired;
  logic        w_adc_start;
  logic        w_busy;
  logic        w_push;
  logic        w_capture_to;
  logic        w_pop;
  logic        w_drop;
  logic        w_en_rise;
  logic        w_full;
  logic        w_empty;
  fifo_entry_t w_push_entry;
  fifo_entry_t w_head;

  assign w_scan_ok      = enable && (ch_mask != '0);
  assign w_wait_expired = (r_wait >= WAIT_LIMIT);
  assign w_en_rise      = enable & ~r_en_d;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_scan_ok) w_next = S_SETUP;
      S_SETUP:   w_next = S_PULSE;
      S_PULSE:   w_next = S_CLEAR;
      S_CLEAR:   w_next = S_WAIT;
      S_WAIT:    if (adc_done || w_wait_expired) w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_HOLD;
      S_HOLD: begin
        if (!w_scan_ok)                 w_next = S_IDLE;
        else if (r_period >= HOLD_EXIT) w_next = S_SETUP;
      end
      default:   w_next = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    w_adc_start  = 1'b0;
    w_busy       = 1'b1;
    w_push       = 1'b0;
    w_capture_to = 1'b0;
    case (r_state)
      S_IDLE:    w_busy = 1'b0;
      S_PULSE:   w_adc_start = 1'b1;
      S_CAPTURE: begin
        w_push       = ~r_timed_out;
        w_capture_to = r_timed_out;
      end
      default: ;
    endcase
  end

  // ---------------- counters, channel and sample registers ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_period    <= '0;
      r_wait      <= '0;
      r_ch        <= '0;
      r_data      <= '0;
      r_timed_out <= 1'b0;
      r_en_d      <= 1'b0;
    end else begin
      r_en_d <= enable;

      if (r_state == S_PULSE)        r_period <= '0;
      else if (r_period != PERIOD_MAX) r_period <= r_period + 1'b1;

      if (r_state == S_PULSE)                     r_wait <= '0;
      else if (r_state == S_WAIT && r_wait != 8'hFF) r_wait <= r_wait + 8'd1;

      // Channel changes only on entry to SETUP, so adc_ch is stable from
      // SETUP through the whole conversion.
      if (r_state == S_IDLE && w_next == S_SETUP)
        r_ch <= lowest_ch(ch_mask);
      else if (r_state == S_HOLD && w_next == S_SETUP)
        r_ch <= next_ch(ch_mask, r_ch);

      // Latch the result when leaving WAIT; done wins over a coincident timeout.
      if (r_state == S_WAIT && w_next == S_CAPTURE) begin
        r_data      <= adc_data;
        r_timed_out <= ~adc_done;
      end
    end
  end

  // ---------------- sticky error flags ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overrun     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_en_rise) begin
        r_overrun     <= 1'b0;
        r_timeout_err <= 1'b0;
      end
      if (w_drop)       r_overrun     <= 1'b1;
      if (w_capture_to) r_timeout_err <= 1'b1;
    end
  end

  // ---------------- sample FIFO ----------------
  assign w_push_entry.ch   = r_ch;
  assign w_push_entry.data = r_data;
  assign w_pop             = ~w_empty & out_ready;
  assign w_drop            = w_push & w_full & ~w_pop;

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fifo_entry_t))
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .o_head_data (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  assign adc_start   = w_adc_start;
  assign adc_ch      = r_ch;
  assign out_data    = w_head.data;
  assign out_ch      = w_head.ch;
  assign out_valid   = ~w_empty;
  assign overrun     = r_overrun;
  assign timeout_err = r_timeout_err;
  assign busy        = w_busy;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
module tb_adc_scan_sequencer;

  localparam int SAMPLE_DIV   = 100;
  localparam int DONE_TIMEOUT = 255;
  localparam int DEPTH        = 8;
  localparam int NEVER        = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        enable = 1'b0;
  logic [7:0]  ch_mask = 8'h00;
  logic        out_ready = 1'b0;
  logic        adc_start;
  logic [2:0]  adc_ch;
  logic        adc_done;
  logic [11:0] adc_data;
  logic [11:0] out_data;
  logic [2:0]  out_ch;
  logic        out_valid;
  logic        overrun;
  logic        timeout_err;
  logic        busy;
  logic [2:0]  dbg_state;

  adc_scan_sequencer #(
    .SAMPLE_DIV   (SAMPLE_DIV),
    .DONE_TIMEOUT (DONE_TIMEOUT),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .ch_mask     (ch_mask),
    .adc_start   (adc_start),
    .adc_ch      (adc_ch),
    .adc_done    (adc_done),
    .adc_data    (adc_data),
    .out_data    (out_data),
    .out_ch      (out_ch),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overrun     (overrun),
    .timeout_err (timeout_err),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // ---------------- check task ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- converter model ----------------
  // Done rises conv_lat posedges after the posedge that sees adc_start;
  // a new start clears done. conv_lat == NEVER means no done at all.
  int         conv_lat = 77;
  int         conv_lat_l;
  int         conv_cnt;
  logic       conv_busy;
  logic [2:0] conv_ch;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      adc_done  <= 1'b0;
      adc_data  <= 12'h000;
      conv_busy <= 1'b0;
      conv_cnt  <= 0;
    end else if (adc_start) begin
      adc_done   <= 1'b0;
      conv_busy  <= (conv_lat != NEVER);
      conv_cnt   <= 0;
      conv_ch    <= adc_ch;
      conv_lat_l <= conv_lat;
    end else if (conv_busy) begin
      conv_cnt <= conv_cnt + 1;
      if (conv_cnt + 1 == conv_lat_l) begin
        adc_done  <= 1'b1;
        adc_data  <= 12'h100 + 12'(conv_ch);
        conv_busy <= 1'b0;
      end
    end
  end

  // ---------------- reference model / scoreboard ----------------
  int fixed_lat = 77;
  int lat_mode  = 0;  // 0: fixed latency, 1: random latency per conversion

  logic [14:0] exp_q[$];
  int          cyc = 0;
  int          n_starts = 0;
  int          n_caps = 0;
  logic        prev_start = 1'b0;
  logic        prev_en = 1'b0;
  logic [2:0]  prev_adc_ch = 3'd0;
  logic        saw_idle = 1'b1;
  int          last_start_cyc = 0;
  int          last_eff = 0;
  logic [2:0]  last_ch = 3'd0;
  logic        pend = 1'b0;
  int          pend_cap_cyc = 0;
  logic        pend_to = 1'b0;
  logic [2:0]  pend_ch = 3'd0;
  logic        m_ovr = 1'b0;
  logic        m_to = 1'b0;

  // Scan order: walk the ascending list of enabled channels, wrapping.
  function automatic logic [2:0] model_ch(input logic [7:0] mask, input logic [2:0] prev,
                                          input logic first);
    int chans[$];
    for (int i = 0; i < 8; i++) if (mask[i]) chans.push_back(i);
    if (chans.size() == 0) return 3'd0;
    if (first) return 3'(chans[0]);
    foreach (chans[k]) if (chans[k] > int'(prev)) return 3'(chans[k]);
    return 3'(chans[0]);
  endfunction

  always @(negedge clk) begin
    int lat;
    int eff;
    int exp_period;
    logic [2:0] exp_ch;
    cyc++;
    if (!reset_n) begin
      exp_q.delete();
      m_ovr       = 1'b0;
      m_to        = 1'b0;
      pend        = 1'b0;
      prev_en     = 1'b0;
      prev_start  = 1'b0;
      prev_adc_ch = 3'd0;
      saw_idle    = 1'b1;
    end else begin
      // registered outputs against model state after the previous edge
      check_val("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
      if (exp_q.size() != 0) check_val("head", {17'd0, out_ch, out_data}, {17'd0, exp_q[0]});
      check_val("overrun", {31'd0, overrun}, {31'd0, m_ovr});
      check_val("timeout_err", {31'd0, timeout_err}, {31'd0, m_to});
      if (!busy) saw_idle = 1'b1;

      // events that take effect at the coming edge
      if (enable && !prev_en) begin
        m_ovr = 1'b0;
        m_to  = 1'b0;
      end
      prev_en = enable;

      if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());

      if (pend && cyc == pend_cap_cyc) begin
        check_val("adc_ch_hold", {29'd0, adc_ch}, {29'd0, pend_ch});
        n_caps++;
        pend = 1'b0;
        if (pend_to) m_to = 1'b1;
        else if (exp_q.size() < DEPTH) exp_q.push_back({pend_ch, 12'h100 + 12'(pend_ch)});
        else m_ovr = 1'b1;
      end

      if (adc_start && !prev_start) begin
        check_val("overlap", {31'd0, pend}, 32'd0);
        exp_ch = model_ch(ch_mask, last_ch, saw_idle);
        check_val("adc_ch", {29'd0, adc_ch}, {29'd0, exp_ch});
        check_val("adc_ch_setup", {29'd0, prev_adc_ch}, {29'd0, exp_ch});
        if (!saw_idle) begin
          exp_period = (last_eff + 5 > SAMPLE_DIV) ? last_eff + 5 : SAMPLE_DIV;
          check_val("period", cyc - last_start_cyc, exp_period);
        end
        if (lat_mode == 0) lat = fixed_lat;
        else begin
          case ($urandom_range(0, 5))
            0:       lat = 254;
            1:       lat = 255;
            2:       lat = 256;
            3:       lat = NEVER;
            default: lat = $urandom_range(1, 150);
          endcase
        end
        conv_lat       = lat;
        pend_to        = (lat == NEVER) || (lat > DONE_TIMEOUT);
        eff            = pend_to ? DONE_TIMEOUT : lat;
        pend           = 1'b1;
        pend_cap_cyc   = cyc + 2 + eff;
        pend_ch        = adc_ch;
        last_start_cyc = cyc;
        last_eff       = eff;
        last_ch        = adc_ch;
        saw_idle       = 1'b0;
        n_starts++;
      end
      prev_start  = adc_start;
      prev_adc_ch = adc_ch;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic en, input logic [7:0] mask, input logic rdy);
    @(posedge clk);
    #1;
    ch_mask   = mask;
    out_ready = rdy;
    enable    = en;
  endtask

  task automatic wait_starts(input int n, input int budget);
    int target;
    int k;
    target = n_starts + n;
    k = 0;
    while (n_starts < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    check_val("start_wait", {31'd0, n_starts >= target}, 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_val("idle_wait", {31'd0, busy}, 32'd0);
  endtask

  task automatic stop_and_drain();
    drive(1'b0, ch_mask, out_ready);
    wait_idle(600);
    drive(1'b0, ch_mask, 1'b1);
    repeat (20) @(posedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_adc_start"}, {31'd0, adc_start}, 32'd0);
    check_val({tag, "_adc_ch"}, {29'd0, adc_ch}, 32'd0);
    check_val({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check_val({tag, "_out_data"}, {20'd0, out_data}, 32'd0);
    check_val({tag, "_out_ch"}, {29'd0, out_ch}, 32'd0);
    check_val({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
    check_val({tag, "_timeout_err"}, {31'd0, timeout_err}, 32'd0);
    check_val({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int caps0;
    int starts0;
    int k;
    int target;

    // reset values
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 reset_n = 1'b1;

    // channels 0 and 2, nominal latency: 100-cycle period, alternating data
    fixed_lat = 77;
    drive(1'b1, 8'h05, 1'b1);
    wait_starts(5, 700);
    stop_and_drain();

    // single channel 3, latency longer than the period: period = latency + 5
    fixed_lat = 120;
    drive(1'b1, 8'h08, 1'b1);
    wait_starts(3, 600);
    fixed_lat = 96;
    wait_starts(2, 400);
    fixed_lat = 95;
    wait_starts(2, 400);
    stop_and_drain();

    // FIFO full: ten conversions with no consumer
    fixed_lat = 77;
    drive(1'b1, 8'h01, 1'b0);
    wait_starts(10, 1300);
    drive(1'b0, 8'h01, 1'b0);
    wait_idle(400);
    check_val("full_valid", {31'd0, out_valid}, 32'd1);
    check_val("full_head_ch", {29'd0, out_ch}, 32'd0);
    check_val("full_head_data", {20'd0, out_data}, 32'h100);
    check_val("full_overrun", {31'd0, overrun}, 32'd1);
    drive(1'b0, 8'h01, 1'b1);
    repeat (20) @(posedge clk);

    // converter never answers: timeout, no push, next channel follows
    fixed_lat = NEVER;
    drive(1'b1, 8'h03, 1'b1);
    wait_starts(2, 700);
    @(negedge clk);
    check_val("to_flag", {31'd0, timeout_err}, 32'd1);
    check_val("to_no_push", {31'd0, out_valid}, 32'd0);
    stop_and_drain();

    // enable drops mid-conversion
    fixed_lat = 77;
    drive(1'b1, 8'h04, 1'b1);
    wait_starts(1, 300);
    caps0 = n_caps;
    repeat (9) @(posedge clk);
    #1 enable = 1'b0;
    k = 0;
    while (n_caps == caps0 && k < 300) begin
      @(posedge clk);
      k++;
    end
    check_val("drop_captured", {31'd0, n_caps > caps0}, 32'd1);
    @(negedge clk);
    check_val("drop_busy_hold", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check_val("drop_busy_idle", {31'd0, busy}, 32'd0);
    starts0 = n_starts;
    repeat (300) @(posedge clk);
    check_val("drop_no_restart", n_starts, starts0);
    drive(1'b0, 8'h04, 1'b1);
    repeat (10) @(posedge clk);

    // reset during WAIT with a sample queued
    drive(1'b1, 8'h06, 1'b0);
    wait_starts(2, 400);
    repeat (30) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    out_ready = 1'b1;
    wait_starts(2, 400);
    stop_and_drain();

    // randomized runs: random mask, latency and consumer backpressure
    lat_mode = 1;
    for (int r = 0; r < 4; r++) begin
      drive(1'b1, 8'($urandom_range(1, 255)), 1'b1);
      target = n_starts + 6;
      k = 0;
      while (n_starts < target && k < 3000) begin
        @(posedge clk);
        #1 out_ready = ($urandom_range(0, 3) != 0);
        k++;
      end
      check_val("rand_starts", {31'd0, n_starts >= target}, 32'd1);
      stop_and_drain();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
